// File: rtl/sram_mem_ctrl.sv
// -----------------------------------------------------------------------------
// sram_mem_ctrl
//
// Memory-stage controller between the EX/MEM register and MEMWB. A 32-bit
// load or store from the instruction in MEM is carried out on an external
// 16-bit asynchronous SRAM as two half-word phases: low half first, then high.
// Each phase lasts SRAM_WAIT+1 cycles. The pipeline is frozen until the
// access completes.
//
// Request/stall handshake:
//   - A request (mem_r_en | mem_w_en) is sampled only in IDLE. At that point
//     the word address and store data are latched.
//   - While freeze=1, upstream holds the request and its operands stable.
//   - ready is high for exactly one cycle (DONE). In that cycle freeze drops,
//     so EX/MEM and MEMWB advance together and MEMWB latches read_data.
//   - A new request is accepted no earlier than the IDLE cycle after DONE.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   mem_r_en, mem_w_en  load / store request (store wins if both are set)
//   alu_result          byte address of the access
//   store_data          word to store
//   read_data           loaded word, valid while ready=1 after a load
//   ready               access completes this cycle
//   freeze              stall IF/ID/EX/EX-MEM registers this cycle
//   sram_addr           SRAM half-word address
//   sram_dq             SRAM data bus, driven only during write phases
//   sram_*_n            active-low SRAM controls (we, oe, ce, ub, lb)
//   state_dbg           current FSM state, for observation only
// -----------------------------------------------------------------------------
module sram_mem_ctrl #(
   parameter int          SRAM_WAIT = 1,
   parameter logic [31:0] ADDR_BASE = 32'd1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        freeze,
   output logic [17:0] sram_addr,
   inout  wire  [15:0] sram_dq,
   output logic        sram_we_n,
   output logic        sram_oe_n,
   output logic        sram_ce_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Phase counter runs 0..SRAM_WAIT inside each half-word phase.
   localparam int CNT_W = (SRAM_WAIT < 1) ? 1 : $clog2(SRAM_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [16:0]       word_q, word_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       read_data_q, read_data_d;

   logic [31:0]       addr_off;
   logic              phase_last;
   logic              dq_oe;
   logic [15:0]       dq_out;

   // Out-of-range addresses wrap silently: the offset is simply truncated.
   assign addr_off   = alu_result - ADDR_BASE;
   assign phase_last = (cnt_q == CNT_LAST);

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         word_q      <= '0;
         wdata_q     <= '0;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         wdata_q     <= wdata_d;
         read_data_q <= read_data_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      read_data_d = read_data_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (mem_r_en | mem_w_en) begin
               word_d  = 17'(addr_off >> 2);
               wdata_d = store_data;
               state_d = mem_w_en ? WR_LO : RD_LO;
            end
         end

         RD_LO: begin
            cnt_d = phase_last ? '0 : cnt_q + 1'b1;
            if (phase_last) begin
               // The SRAM has had the full phase to settle; capture at its end.
               read_data_d[15:0] = sram_dq;
               state_d           = RD_HI;
            end
         end

         RD_HI: begin
            cnt_d = phase_last ? '0 : cnt_q + 1'b1;
            if (phase_last) begin
               read_data_d[31:16] = sram_dq;
               state_d            = DONE;
            end
         end

         WR_LO: begin
            cnt_d = phase_last ? '0 : cnt_q + 1'b1;
            if (phase_last) begin
               state_d = WR_HI;
            end
         end

         WR_HI: begin
            cnt_d = phase_last ? '0 : cnt_q + 1'b1;
            if (phase_last) begin
               state_d = DONE;
            end
         end

         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end

         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // SRAM interface and handshake outputs (decoded from the current state)
   // --------------------------------------------------------------------------
   always_comb begin
      sram_ce_n = 1'b1;
      sram_oe_n = 1'b1;
      sram_we_n = 1'b1;
      sram_ub_n = 1'b1;
      sram_lb_n = 1'b1;
      sram_addr = '0;
      dq_oe     = 1'b0;
      dq_out    = '0;
      ready     = 1'b0;

      case (state_q)
         RD_LO, RD_HI: begin
            sram_ce_n = 1'b0;
            sram_oe_n = 1'b0;
            sram_ub_n = 1'b0;
            sram_lb_n = 1'b0;
            sram_addr = {word_q, (state_q == RD_HI)};
         end

         WR_LO, WR_HI: begin
            // oe_n stays high so the SRAM never drives while we do.
            sram_ce_n = 1'b0;
            sram_we_n = 1'b0;
            sram_ub_n = 1'b0;
            sram_lb_n = 1'b0;
            sram_addr = {word_q, (state_q == WR_HI)};
            dq_oe     = 1'b1;
            dq_out    = (state_q == WR_HI) ? wdata_q[31:16] : wdata_q[15:0];
         end

         DONE: begin
            ready = 1'b1;
         end

         default: begin
            ready = 1'b0;
         end
      endcase
   end

   assign sram_dq   = dq_oe ? dq_out : 16'bz;
   assign read_data = read_data_q;
   assign freeze    = (mem_r_en | mem_w_en) & ~ready;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_ctrl
//
// Two controllers are exercised side by side: inst 0 with SRAM_WAIT=1 and
// inst 1 with SRAM_WAIT=3, each on its own behavioural asynchronous SRAM.
// A transaction-level reference model tracks each access by its cycle offset
// since acceptance and predicts every SRAM control, address, data and
// handshake output; a compare process checks them on every falling edge.
// Directed accesses pin latency, counts and memory contents to literal values.
// -----------------------------------------------------------------------------
module tb_sram_mem_ctrl;

   localparam logic [31:0] BASE = 32'd1024;

   int total = 0;
   int bad   = 0;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [2];
   logic        r_en  [2];
   logic        w_en  [2];
   logic [31:0] alu   [2];
   logic [31:0] sdat  [2];
   logic [31:0] rdata [2];
   logic        rdy   [2];
   logic        frz   [2];
   logic        we_n  [2];
   logic        oe_n  [2];
   logic        ce_n  [2];
   logic        ub_n  [2];
   logic        lb_n  [2];
   logic [17:0] saddr [2];
   logic [2:0]  st_dbg[2];
   logic [15:0] dq_s  [2];
   wire  [15:0] dq0;
   wire  [15:0] dq1;

   // Behavioural SRAM contents (what the bus actually wrote) and the
   // reference model's idea of what memory must hold.
   logic [15:0] sram_mem [2][262144];
   logic [15:0] ref_mem  [2][262144];

   bit chk_en = 1'b0;

   // ---------------------------------------------------------------- DUTs
   sram_mem_ctrl #(.SRAM_WAIT(1), .ADDR_BASE(BASE)) dut0 (
      .clock(clk), .reset(rst[0]), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
      .alu_result(alu[0]), .store_data(sdat[0]), .read_data(rdata[0]),
      .ready(rdy[0]), .freeze(frz[0]), .sram_addr(saddr[0]), .sram_dq(dq0),
      .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0]), .sram_ce_n(ce_n[0]),
      .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0]), .state_dbg(st_dbg[0])
   );

   sram_mem_ctrl #(.SRAM_WAIT(3), .ADDR_BASE(BASE)) dut1 (
      .clock(clk), .reset(rst[1]), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
      .alu_result(alu[1]), .store_data(sdat[1]), .read_data(rdata[1]),
      .ready(rdy[1]), .freeze(frz[1]), .sram_addr(saddr[1]), .sram_dq(dq1),
      .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1]), .sram_ce_n(ce_n[1]),
      .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1]), .state_dbg(st_dbg[1])
   );

   // ---------------------------------------------------------------- SRAM model
   assign dq0 = (!ce_n[0] && !oe_n[0] && we_n[0]) ? sram_mem[0][saddr[0]] : 16'bz;
   assign dq1 = (!ce_n[1] && !oe_n[1] && we_n[1]) ? sram_mem[1][saddr[1]] : 16'bz;
   assign dq_s[0] = dq0;
   assign dq_s[1] = dq1;

   always @(negedge clk) begin
      if (!ce_n[0] && !we_n[0]) sram_mem[0][saddr[0]] = dq0;
      if (!ce_n[1] && !we_n[1]) sram_mem[1][saddr[1]] = dq1;
   end

   // ---------------------------------------------------------------- check helper
   task automatic check(input string name, input int i,
                        input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
      end
   endtask

   function automatic int plen(input int i);
      return (i == 0) ? 2 : 4;
   endfunction

   // ---------------------------------------------------------------- reference model
   // busy/t: t counts cycles since the request was accepted; 1..2P are the
   // SRAM phases (first P low half), 2P+1 is the completion cycle.
   bit          busy  [2];
   int          t     [2];
   bit          m_wr  [2];
   logic [16:0] m_word[2];
   logic [31:0] m_sd  [2];
   logic [31:0] m_rd  [2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [31:0] off;
         if (rst[i]) begin
            busy[i] = 1'b0;
            t[i]    = 0;
            m_rd[i] = '0;
         end else if (!busy[i]) begin
            if (r_en[i] || w_en[i]) begin
               off       = alu[i] - BASE;
               busy[i]   = 1'b1;
               t[i]      = 1;
               m_wr[i]   = w_en[i];
               m_word[i] = off[18:2];
               m_sd[i]   = sdat[i];
               if (w_en[i]) begin
                  ref_mem[i][{off[18:2], 1'b0}] = sdat[i][15:0];
                  ref_mem[i][{off[18:2], 1'b1}] = sdat[i][31:16];
               end
            end
         end else if (t[i] == 2 * plen(i) + 1) begin
            busy[i] = 1'b0;
            t[i]    = 0;
         end else begin
            t[i] = t[i] + 1;
            if (t[i] == 2 * plen(i) + 1 && !m_wr[i])
               m_rd[i] = {ref_mem[i][{m_word[i], 1'b1}], ref_mem[i][{m_word[i], 1'b0}]};
         end
      end
   end

   // ---------------------------------------------------------------- compare process
   int rdy_pulses[2];

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            int          p;
            bit          done;
            bit          active;
            bit          hi;
            logic [4:0]  ctl_e;
            logic [17:0] a_e;
            p      = plen(i);
            done   = busy[i] && (t[i] == 2 * p + 1);
            active = busy[i] && !done;
            hi     = (t[i] > p);
            ctl_e  = 5'b11111;                 // {ce, oe, we, ub, lb}
            a_e    = '0;
            if (active) begin
               a_e   = {m_word[i], hi};
               ctl_e = m_wr[i] ? 5'b01000 : 5'b00100;
               if (m_wr[i])
                  check("dq_write", i, 32'(dq_s[i]), 32'(hi ? m_sd[i][31:16] : m_sd[i][15:0]));
            end
            if (rdy[i]) rdy_pulses[i]++;
            check("ready", i, 32'(rdy[i]), 32'(done));
            check("freeze", i, 32'(frz[i]), 32'((r_en[i] | w_en[i]) & ~done));
            check("ctl", i, 32'({ce_n[i], oe_n[i], we_n[i], ub_n[i], lb_n[i]}), 32'(ctl_e));
            check("addr", i, 32'(saddr[i]), 32'(a_e));
            if (!(active && !m_wr[i]))
               check("read_data", i, rdata[i], m_rd[i]);
         end
      end
   end

   // ---------------------------------------------------------------- driver tasks
   int          res_cyc, res_we, res_oe, res_frz;
   logic [31:0] res_rd;
   logic [17:0] res_first, res_last;

   // Called just after a rising edge with the DUT in IDLE. Holds the request
   // until the completion cycle, then drops it one edge later.
   task automatic access(input int i, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
      bit got;
      bit seen;
      r_en[i] = r; w_en[i] = w; alu[i] = a; sdat[i] = d;
      res_cyc = 0; res_we = 0; res_oe = 0; res_frz = 0;
      res_first = '0; res_last = '0; got = 1'b0; seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (!ce_n[i]) begin
            if (!got) res_first = saddr[i];
            got      = 1'b1;
            res_last = saddr[i];
         end
         if (!we_n[i]) res_we++;
         if (!oe_n[i]) res_oe++;
         if (frz[i])   res_frz++;
         if (rdy[i]) begin
            seen = 1'b1;
            break;
         end
         res_cyc++;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL timeout inst%0d: got no ready after %0d cycles expected completion", i, res_cyc);
      end
      res_rd = rdata[i];
      @(posedge clk); #1;
      r_en[i] = 1'b0; w_en[i] = 1'b0;
   endtask

   task automatic rand_run(input int i, input int n);
      for (int wd = 0; wd < 16; wd++) access(i, 1'b0, 1'b1, BASE + 32'(wd * 4), $urandom);
      for (int k = 0; k < n; k++) begin
         int op;
         int wd;
         op = $urandom_range(0, 3);
         wd = $urandom_range(0, 15);
         if (op == 3) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end else begin
            access(i, op != 1, op != 0, BASE + 32'(wd * 4) + 32'($urandom_range(0, 3)), $urandom);
         end
      end
      for (int wd = 0; wd < 16; wd++) begin
         check("mem_lo", i, 32'(sram_mem[i][{17'(wd), 1'b0}]), 32'(ref_mem[i][{17'(wd), 1'b0}]));
         check("mem_hi", i, 32'(sram_mem[i][{17'(wd), 1'b1}]), 32'(ref_mem[i][{17'(wd), 1'b1}]));
      end
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int p0;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; r_en[i] = 1'b0; w_en[i] = 1'b0; alu[i] = '0; sdat[i] = '0;
         rdy_pulses[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b0; rst[1] = 1'b0;
      chk_en = 1'b1;

      // Reset state.
      @(negedge clk);
      check("rst_ready", 0, 32'(rdy[0]), 32'd0);
      check("rst_ctl", 0, 32'({ce_n[0], oe_n[0], we_n[0], ub_n[0], lb_n[0]}), 32'h1f);
      check("rst_rdata", 0, rdata[0], 32'd0);
      @(posedge clk); #1;

      // ---- inst 0, SRAM_WAIT=1
      access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
      check("st_latency", 0, 32'(res_cyc), 32'd5);
      check("st_we_cycles", 0, 32'(res_we), 32'd4);
      check("st_freeze_cycles", 0, 32'(res_frz), 32'd5);
      check("st_mem2", 0, 32'(sram_mem[0][2]), 32'hBEEF);
      check("st_mem3", 0, 32'(sram_mem[0][3]), 32'hDEAD);

      access(0, 1'b1, 1'b0, 32'd1028, 32'h0);
      check("ld_latency", 0, 32'(res_cyc), 32'd5);
      check("ld_data", 0, res_rd, 32'hDEADBEEF);
      check("ld_oe_cycles", 0, 32'(res_oe), 32'd4);
      check("ld_we_cycles", 0, 32'(res_we), 32'd0);

      access(0, 1'b1, 1'b1, 32'd1024, 32'h12345678);
      check("both_mem0", 0, 32'(sram_mem[0][0]), 32'h5678);
      check("both_mem1", 0, 32'(sram_mem[0][1]), 32'h1234);
      check("both_oe_cycles", 0, 32'(res_oe), 32'd0);

      p0 = rdy_pulses[0];
      access(0, 1'b0, 1'b1, 32'd1032, 32'hA5A55A5A);
      access(0, 1'b1, 1'b0, 32'd1032, 32'h0);
      check("b2b_latency", 0, 32'(res_cyc), 32'd5);
      check("b2b_data", 0, res_rd, 32'hA5A55A5A);
      check("b2b_pulses", 0, 32'(rdy_pulses[0] - p0), 32'd2);

      // Reset during the high write phase (cycles 3..4 with P=2).
      w_en[0] = 1'b1; alu[0] = BASE + 32'd800; sdat[0] = 32'h0BADF00D;
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b1;
      @(negedge clk);
      check("pre_rst_addr", 0, 32'(saddr[0]), 32'h191);
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_rst_ready", 0, 32'(rdy[0]), 32'd0);
      check("mid_rst_freeze", 0, 32'(frz[0]), 32'd1);
      check("mid_rst_ctl", 0, 32'({ce_n[0], oe_n[0], we_n[0], ub_n[0], lb_n[0]}), 32'h1f);
      check("mid_rst_addr", 0, 32'(saddr[0]), 32'd0);
      check("mid_rst_rdata", 0, rdata[0], 32'd0);
      @(posedge clk); #1;
      rst[0] = 1'b0; w_en[0] = 1'b0;
      @(posedge clk); #1;

      rand_run(0, 40);

      // ---- inst 1, SRAM_WAIT=3
      access(1, 1'b0, 1'b1, 32'd1028, 32'hCAFEF00D);
      check("w3_st_latency", 1, 32'(res_cyc), 32'd9);
      check("w3_st_we_cycles", 1, 32'(res_we), 32'd8);
      access(1, 1'b1, 1'b0, 32'd1028, 32'h0);
      check("w3_ld_latency", 1, 32'(res_cyc), 32'd9);
      check("w3_ld_data", 1, res_rd, 32'hCAFEF00D);
      check("w3_ld_oe_cycles", 1, 32'(res_oe), 32'd8);

      access(1, 1'b0, 1'b1, 32'd1020, 32'h13579BDF);
      check("wrap_addr_lo", 1, 32'(res_first), 32'h3FFFE);
      check("wrap_addr_hi", 1, 32'(res_last), 32'h3FFFF);
      check("wrap_mem_lo", 1, 32'(sram_mem[1][18'h3FFFE]), 32'h9BDF);
      check("wrap_mem_hi", 1, 32'(sram_mem[1][18'h3FFFF]), 32'h1357);
      access(1, 1'b1, 1'b0, 32'd1020, 32'h0);
      check("wrap_ld_data", 1, res_rd, 32'h13579BDF);

      rand_run(1, 30);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
